// File: rtl/ctrl_cmd_serializer.sv
// ---------------------------------------------------------------------------
// ctrl_cmd_serializer
//
// Host-side transmitter for the control byte protocol. Accepts one whole
// command request (opcode plus block / data / instruction / delay fields),
// then emits the exact byte sequence the control unit expects, one byte per
// `next` acknowledge from the receiver. Sits between the SPI/MCU bridge (or
// a bench driver) and control_unit.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   req_valid       command request present
//   req_ready       serializer can accept a request this cycle (IDLE only)
//   req_cmd         opcode (COMMAND_* code)
//   req_block       target block index (8*block_bytes bits)
//   req_data        register or gain value (data_width bits)
//   req_instr       block instruction word
//   req_delay_size  delay buffer size
//   req_init_delay  initial delay
//   tx_byte         byte to the control unit (its in_byte)
//   tx_valid        tx_byte valid (its in_valid)
//   tx_next         byte-consumed pulse from the control unit (its next)
//   busy            high from acceptance until the last byte is acknowledged
//   done            one-cycle pulse when a command's last byte is acknowledged
//   ack_timeout     one-cycle pulse when a command is aborted on timeout
// ---------------------------------------------------------------------------
module ctrl_cmd_serializer #(
  parameter int n_blocks    = 256,
  parameter int data_width  = 16,
  parameter int ACK_TIMEOUT = 65536,
  localparam int block_bytes = (n_blocks > 256) ? 2 : 1,
  localparam int data_bytes  = (data_width == 24) ? 3 : 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_cmd,
  input  logic [8*block_bytes-1:0] req_block,
  input  logic [data_width-1:0]    req_data,
  input  logic [31:0]              req_instr,
  input  logic [23:0]              req_delay_size,
  input  logic [23:0]              req_init_delay,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_next,
  output logic                     busy,
  output logic                     done,
  output logic                     ack_timeout
);

  // Opcode values mirror the COMMAND_* definitions in controller.vh.
  localparam logic [7:0] COMMAND_BEGIN_PROGRAM      = 8'h01;
  localparam logic [7:0] COMMAND_END_PROGRAM        = 8'h02;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h03;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_0  = 8'h04;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_1  = 8'h05;
  localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h06;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h07;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h08;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_0 = 8'h09;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_1 = 8'h0A;
  localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h0B;

  localparam int DATA_BITS = 8 * data_bytes;
  localparam int CNT_W     = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  // Total byte counts (opcode included) per command class.
  localparam logic [2:0] LEN_INSTR = 3'(1 + block_bytes + 4);
  localparam logic [2:0] LEN_REG   = 3'(1 + block_bytes + data_bytes);
  localparam logic [2:0] LEN_ALLOC = 3'd7;
  localparam logic [2:0] LEN_GAIN  = 3'(1 + data_bytes);
  localparam logic [2:0] LEN_BARE  = 3'd1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;

  // Command bytes left-aligned: the byte on the wire is always [55:48].
  logic [55:0]        shift_buf;
  logic [55:0]        next_shift_buf;
  logic [2:0]         byte_index;
  logic [2:0]         next_byte_index;
  logic [2:0]         byte_total;
  logic [2:0]         next_byte_total;
  logic [CNT_W-1:0]   wait_count;
  logic [CNT_W-1:0]   next_wait_count;

  logic               next_req_ready;
  logic               next_tx_valid;
  logic               next_busy;
  logic               next_done;
  logic               next_ack_timeout;

  logic [DATA_BITS-1:0] data_field;
  logic [55:0]          load_raw;
  logic [2:0]           load_len;
  logic [5:0]           load_shift;
  logic [55:0]          load_buf;

  assign data_field = DATA_BITS'(req_data);
  assign tx_byte    = shift_buf[55:48];

  // Assemble the request right-aligned with its length, then left-align it.
  always_comb begin
    load_raw = 56'd0;
    load_len = LEN_BARE;
    case (req_cmd)
      COMMAND_WRITE_BLOCK_INSTR: begin
        load_raw = 56'({req_cmd, req_block, req_instr});
        load_len = LEN_INSTR;
      end
      COMMAND_WRITE_BLOCK_REG_0,
      COMMAND_WRITE_BLOCK_REG_1,
      COMMAND_UPDATE_BLOCK_REG_0,
      COMMAND_UPDATE_BLOCK_REG_1: begin
        load_raw = 56'({req_cmd, req_block, data_field});
        load_len = LEN_REG;
      end
      COMMAND_ALLOC_DELAY: begin
        load_raw = 56'({req_cmd, req_delay_size, req_init_delay});
        load_len = LEN_ALLOC;
      end
      COMMAND_SET_INPUT_GAIN,
      COMMAND_SET_OUTPUT_GAIN: begin
        load_raw = 56'({req_cmd, data_field});
        load_len = LEN_GAIN;
      end
      COMMAND_BEGIN_PROGRAM,
      COMMAND_END_PROGRAM,
      COMMAND_COMMIT_REG_UPDATES: begin
        load_raw = 56'(req_cmd);
        load_len = LEN_BARE;
      end
      default: begin
        // Unknown opcodes still go out, but with no payload.
        load_raw = 56'(req_cmd);
        load_len = LEN_BARE;
      end
    endcase
    load_shift = {3'd7 - load_len, 3'b000};
    load_buf   = load_raw << load_shift;
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_buf   <= 56'd0;
      byte_index  <= 3'd0;
      byte_total  <= 3'd0;
      wait_count  <= '0;
      req_ready   <= 1'b1;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      shift_buf   <= next_shift_buf;
      byte_index  <= next_byte_index;
      byte_total  <= next_byte_total;
      wait_count  <= next_wait_count;
      req_ready   <= next_req_ready;
      tx_valid    <= next_tx_valid;
      busy        <= next_busy;
      done        <= next_done;
      ack_timeout <= next_ack_timeout;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    next_state       = state;
    next_shift_buf   = shift_buf;
    next_byte_index  = byte_index;
    next_byte_total  = byte_total;
    next_wait_count  = wait_count;
    next_req_ready   = req_ready;
    next_tx_valid    = tx_valid;
    next_busy        = busy;
    next_done        = 1'b0;
    next_ack_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          next_state      = SEND;
          next_shift_buf  = load_buf;
          next_byte_index = 3'd0;
          next_byte_total = load_len;
          next_wait_count = '0;
          next_req_ready  = 1'b0;
          next_tx_valid   = 1'b1;
          next_busy       = 1'b1;
        end else begin
          // tx_next is deliberately ignored here.
          next_req_ready  = 1'b1;
          next_tx_valid   = 1'b0;
          next_busy       = 1'b0;
        end
      end

      SEND: begin
        // An acknowledge takes priority over a timeout in the same cycle.
        if (tx_next) begin
          next_wait_count = '0;
          if (byte_index == (byte_total - 3'd1)) begin
            next_state      = IDLE;
            next_shift_buf  = 56'd0;
            next_byte_index = 3'd0;
            next_req_ready  = 1'b1;
            next_tx_valid   = 1'b0;
            next_busy       = 1'b0;
            next_done       = 1'b1;
          end else begin
            next_shift_buf  = {shift_buf[47:0], 8'h00};
            next_byte_index = byte_index + 3'd1;
          end
        end else if (wait_count == CNT_LAST) begin
          next_state       = IDLE;
          next_shift_buf   = 56'd0;
          next_byte_index  = 3'd0;
          next_wait_count  = '0;
          next_req_ready   = 1'b1;
          next_tx_valid    = 1'b0;
          next_busy        = 1'b0;
          next_ack_timeout = 1'b1;
        end else begin
          next_wait_count  = wait_count + CNT_W'(1);
        end
      end

      default: begin
        next_state      = IDLE;
        next_shift_buf  = 56'd0;
        next_byte_index = 3'd0;
        next_wait_count = '0;
        next_req_ready  = 1'b1;
        next_tx_valid   = 1'b0;
        next_busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_cmd_serializer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_cmd_serializer
//
// Directed bench for ctrl_cmd_serializer (ACK_TIMEOUT shortened to 16).
// A table of commands with hand-computed byte sequences is driven through a
// responder that acknowledges each byte after a per-vector delay; hand-written
// sequences cover timeout abort, stray tx_next in IDLE and mid-command reset.
// ---------------------------------------------------------------------------
module tb_ctrl_cmd_serializer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [7:0]  req_block;
  logic [15:0] req_data;
  logic [31:0] req_instr;
  logic [23:0] req_delay_size;
  logic [23:0] req_init_delay;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_next;
  logic        busy;
  logic        done;
  logic        ack_timeout;

  int checks;
  int failures;

  ctrl_cmd_serializer #(
    .n_blocks    (256),
    .data_width  (16),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_block      (req_block),
    .req_data       (req_data),
    .req_instr      (req_instr),
    .req_delay_size (req_delay_size),
    .req_init_delay (req_init_delay),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .tx_next        (tx_next),
    .busy           (busy),
    .done           (done),
    .ack_timeout    (ack_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  block;
    logic [15:0] data;
    logic [31:0] instr;
    logic [23:0] dsize;
    logic [23:0] dinit;
    int          n;
    logic [55:0] bytes;   // expected wire bytes, left-aligned
    int          delay;   // cycles before each acknowledge
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue a request at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input vec_t v);
    @(negedge clk);
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    req_cmd        = v.cmd;
    req_block      = v.block;
    req_data       = v.data;
    req_instr      = v.instr;
    req_delay_size = v.dsize;
    req_init_delay = v.dinit;
    req_valid      = 1'b1;
    @(negedge clk);
    req_valid      = 1'b0;
  endtask

  // Issue a command and acknowledge every byte, checking sequence, hold and done.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] exp_byte;
    logic [55:0] bytes_v;
    bytes_v = v.bytes;
    issue(v);
    for (int i = 0; i < v.n; i++) begin
      exp_byte = bytes_v[55 - 8*i -: 8];
      chk($sformatf("v%0d_b%0d_valid", idx, i), {63'd0, tx_valid}, 64'd1);
      chk($sformatf("v%0d_b%0d_byte", idx, i), {56'd0, tx_byte}, {56'd0, exp_byte});
      chk($sformatf("v%0d_b%0d_busy", idx, i), {62'd0, busy, req_ready}, 64'd2);
      for (int w = 0; w < v.delay; w++) begin
        @(negedge clk);
        chk($sformatf("v%0d_b%0d_hold", idx, i), {55'd0, tx_valid, tx_byte}, {55'd0, 1'b1, exp_byte});
      end
      tx_next = 1'b1;
      @(negedge clk);
      tx_next = 1'b0;
    end
    chk($sformatf("v%0d_end", idx), {59'd0, done, tx_valid, busy, ack_timeout, req_ready}, 64'h11);
    @(negedge clk);
    chk($sformatf("v%0d_done_clear", idx), {62'd0, done, tx_valid}, 64'd0);
  endtask

  int valid_cycles;
  int done_seen;
  vec_t v_local;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_cmd = 8'h00;
    req_block = 8'h00;
    req_data = 16'h0000;
    req_instr = 32'h0;
    req_delay_size = 24'h0;
    req_init_delay = 24'h0;
    tx_next = 1'b0;

    //            cmd    blk    data      instr          size        init        n  bytes                 delay
    vecs[0]  = '{8'h03, 8'h05, 16'h0000, 32'hDEADBEEF, 24'h000000, 24'h000000, 6, 56'h0305DEADBEEF00, 1};
    vecs[1]  = '{8'h05, 8'h2A, 16'h8001, 32'h00000000, 24'h000000, 24'h000000, 4, 56'h052A8001000000, 7};
    vecs[2]  = '{8'h06, 8'h00, 16'h0000, 32'h00000000, 24'h012345, 24'h000010, 7, 56'h06012345000010, 0};
    vecs[3]  = '{8'h02, 8'hEE, 16'hEEEE, 32'hEEEEEEEE, 24'hEEEEEE, 24'hEEEEEE, 1, 56'h02000000000000, 2};
    vecs[4]  = '{8'h01, 8'h00, 16'h0000, 32'h00000000, 24'h000000, 24'h000000, 1, 56'h01000000000000, 0};
    vecs[5]  = '{8'h07, 8'h99, 16'hABCD, 32'h11111111, 24'h000000, 24'h000000, 3, 56'h07ABCD00000000, 3};
    vecs[6]  = '{8'h09, 8'h7F, 16'h0102, 32'h00000000, 24'h000000, 24'h000000, 4, 56'h097F0102000000, 1};
    vecs[7]  = '{8'h0B, 8'h12, 16'h3456, 32'h789ABCDE, 24'h000000, 24'h000000, 1, 56'h0B000000000000, 0};
    vecs[8]  = '{8'hFF, 8'h55, 16'h5555, 32'h55555555, 24'h555555, 24'h555555, 1, 56'hFF000000000000, 1};
    vecs[9]  = '{8'h06, 8'h00, 16'h0000, 32'h00000000, 24'hFEDCBA, 24'h123456, 7, 56'h06FEDCBA123456, 15};
    vecs[10] = '{8'h04, 8'h33, 16'h5AA5, 32'h00000000, 24'h000000, 24'h000000, 4, 56'h04335AA5000000, 0};
    vecs[11] = '{8'h0A, 8'h01, 16'hFFFF, 32'h00000000, 24'h000000, 24'h000000, 4, 56'h0A01FFFF000000, 1};

    repeat (3) @(negedge clk);
    chk("reset_state", {53'd0, req_ready, tx_valid, tx_byte, busy, done, ack_timeout},
        {53'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      run_vec(vecs[k], k);
    end

    // Stray acknowledge while idle must do nothing.
    @(negedge clk);
    tx_next = 1'b1;
    @(negedge clk);
    tx_next = 1'b0;
    chk("idle_next_ignored", {60'd0, done, tx_valid, busy, req_ready}, 64'd1);
    @(negedge clk);
    chk("idle_next_no_pulse", {62'd0, done, ack_timeout}, 64'd0);

    // Timeout: no acknowledge after the opcode.
    v_local = '{8'h03, 8'h05, 16'h0000, 32'hDEADBEEF, 24'h0, 24'h0, 6, 56'h0, 0};
    issue(v_local);
    valid_cycles = 0;
    done_seen = 0;
    while (tx_valid && valid_cycles < 40) begin
      valid_cycles++;
      if (done || ack_timeout) done_seen++;
      chk("to_byte_held", {56'd0, tx_byte}, 64'h03);
      @(negedge clk);
    end
    chk("to_valid_cycles", 64'(valid_cycles), 64'd16);
    chk("to_no_early_pulse", 64'(done_seen), 64'd0);
    chk("to_abort", {59'd0, ack_timeout, done, tx_valid, busy, req_ready}, 64'h11);
    @(negedge clk);
    chk("to_after", {61'd0, ack_timeout, done, req_ready}, 64'd1);

    // Reset after two of four bytes acknowledged.
    v_local = '{8'h04, 8'h11, 16'h2233, 32'h0, 24'h0, 24'h0, 4, 56'h0, 0};
    issue(v_local);
    chk("rst_b0", {56'd0, tx_byte}, 64'h04);
    tx_next = 1'b1;
    @(negedge clk);
    tx_next = 1'b0;
    chk("rst_b1", {56'd0, tx_byte}, 64'h11);
    tx_next = 1'b1;
    @(negedge clk);
    tx_next = 1'b0;
    chk("rst_b2", {55'd0, tx_valid, tx_byte}, {55'd0, 1'b1, 8'h22});
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd", {52'd0, tx_valid, busy, req_ready, done, tx_byte}, {52'd0, 4'b0010, 8'h00});
    reset = 1'b0;
    v_local = '{8'h08, 8'h00, 16'h1234, 32'h0, 24'h0, 24'h0, 3, 56'h08123400000000, 1};
    run_vec(v_local, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_cmd_serializer.md
Name: ctrl_cmd_serializer

Overview:
- Host-side transmitter for the control byte protocol.
- Accepts one parallel command request at a time: opcode plus block, data, instruction and delay fields.
- Emits the exact byte sequence the control unit expects, pacing on its one-cycle `next` acknowledge.
- Placement: sits between the SPI/MCU bridge (or a bench driver) and `control_unit`, so upstream logic issues whole commands instead of raw bytes.

Parameters:
- n_blocks, 256, number of pipeline blocks; block_bytes = (n_blocks > 256) ? 2 : 1.
- data_width, 16, register data width; data_bytes = (data_width == 24) ? 3 : 2.
- ACK_TIMEOUT, 65536, cycles to wait for `next` on one byte before aborting.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  command request present.
- req_ready  out  1  serializer can accept a request this cycle.
- req_cmd  in  8  opcode, one of the COMMAND_* codes in controller.vh.
- req_block  in  8*block_bytes  target block index.
- req_data  in  data_width  register or gain value.
- req_instr  in  32  block instruction word.
- req_delay_size  in  24  delay buffer size.
- req_init_delay  in  24  initial delay.
- tx_byte  out  8  byte to the control unit (its `in_byte`).
- tx_valid  out  1  tx_byte valid (its `in_valid`).
- tx_next  in  1  byte-consumed pulse from the control unit (its `next`).
- busy  out  1  high from acceptance until the last byte is acknowledged.
- done  out  1  one-cycle pulse when the last byte of a command is acknowledged.
- ack_timeout  out  1  one-cycle pulse when a command is aborted on timeout.

Behaviour:
- Reset: state IDLE; req_ready=1; tx_valid=0; tx_byte=0; busy=0; done=0; ack_timeout=0; byte index=0; timeout counter=0.
- Reset mid-command drops tx_valid the next cycle and discards the shift buffer.
- States:
  - IDLE: req_ready=1.
  - SEND: tx_valid=1, req_ready=0.
- Acceptance: when req_valid && req_ready at edge N:
  - Latch all fields into a 56-bit shift buffer; compute total length L.
  - Enter SEND at N+1 with tx_byte=req_cmd, tx_valid=1, busy=1.
  - req_ready returns to 1 only in IDLE, so there is no back-to-back acceptance inside a command.
- Payload length (bytes after opcode) and order, most significant first, to match the receiver's left-shift assembly:
  - WRITE_BLOCK_INSTR: block (block_bytes), then instr[31:24] ... instr[7:0].
  - WRITE_BLOCK_REG_0/1 and UPDATE_BLOCK_REG_0/1: block, then data MSB..LSB (data_bytes).
  - ALLOC_DELAY: delay_size[23:16], [15:8], [7:0], then init_delay[23:16], [15:8], [7:0].
  - SET_INPUT_GAIN / SET_OUTPUT_GAIN: data MSB..LSB.
  - BEGIN_PROGRAM, END_PROGRAM, COMMIT_REG_UPDATES, and any unknown opcode: 0 payload bytes; only the opcode is sent.
- Handshake:
  - tx_byte/tx_valid are held stable until tx_next is sampled high.
  - On tx_next at edge M: if the acknowledged byte was the last of L, go to IDLE at M+1 (tx_valid=0, busy=0, done=1 for that one cycle). Otherwise present the next byte at M+1 with tx_valid staying 1.
  - The receiver blocks resampling in the cycle its `next` is high, so a continuous tx_valid never double-sends a byte.
- tx_next while in IDLE is ignored: no state change, no pulse.
- Timeout:
  - Counter clears on every tx_next and on acceptance; increments each SEND cycle without tx_next.
  - At ACK_TIMEOUT-1: ack_timeout pulses, tx_valid=0, busy=0, return to IDLE. done is not pulsed.
- Simultaneous tx_next and timeout in the same cycle: tx_next wins and the counter clears.
- Throughput: at most one byte per 2 cycles, bounded by the receiver.

Test Plan:
- WRITE_BLOCK_INSTR, block=0x05, instr=0xDEADBEEF, responder pulses next 1 cycle after each valid byte -> tx_byte sequence {cmd, 05, DE, AD, BE, EF}; done pulses once after the 6th ack; busy high throughout.
- WRITE_BLOCK_REG_1, block=0x2A, data=0x8001, responder delays next by 7 cycles -> tx_byte held stable through each wait; sequence {cmd, 2A, 80, 01}.
- ALLOC_DELAY, size=0x012345, init=0x000010 -> sequence {cmd, 01, 23, 45, 00, 00, 10}; then END_PROGRAM -> single byte; done pulses after its ack.
- Loopback into control_unit: BEGIN_PROGRAM, WRITE_BLOCK_INSTR, END_PROGRAM -> block_instr_write pulses for block 5 with instr_out=0xDEADBEEF; swap_pipelines pulses once.
- ACK_TIMEOUT=16, no tx_next after opcode -> ack_timeout pulses at the 16th SEND cycle; tx_valid=0; req_ready=1 the next cycle; no done pulse.
- Reset asserted after 2 of 4 bytes acknowledged -> tx_valid=0 the next cycle; a fresh SET_OUTPUT_GAIN then transmits correctly from the opcode.
